// File: rtl/axi_rgbled_pwm_pkg.sv
// Shared register map, version word and bit positions for the RGB LED PWM controller.
package axi_rgbled_pwm_pkg;

  localparam logic [7:0] ADDR_VERSION    = 8'h00;
  localparam logic [7:0] ADDR_ID         = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH    = 8'h02;
  localparam logic [7:0] ADDR_CONFIG     = 8'h03;
  localparam logic [7:0] ADDR_CTRL       = 8'h04;
  localparam logic [7:0] ADDR_PRESCALE   = 8'h05;
  localparam logic [7:0] ADDR_COLOR_BASE = 8'h10;

  localparam logic [31:0] VERSION = 32'h0001_0061;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLR_BIT    = 1;

  // Colour lane index inside a packed COLOR word, counted in PWM_WIDTH slices.
  localparam int COL_BLUE  = 0;
  localparam int COL_GREEN = 1;
  localparam int COL_RED   = 2;

endpackage

// File: rtl/rgbled_pwm_chan.sv
// One PWM colour lane: duty shadow that only moves at safe points, compare, output flop.
module rgbled_pwm_chan
  import axi_rgbled_pwm_pkg::*;
#(
  parameter int PWM_WIDTH  = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 clr,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic [PWM_WIDTH-1:0] period_cnt,
  output logic                 pwm_o
);

  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PWM_WIDTH-1:0] shadow_q, shadow_d;
  logic                 pwm_q, pwm_d;

  always_comb begin
    shadow_d = shadow_q;
    // Clear wins over load: the source register is being zeroed on the same edge.
    if (clr) begin
      shadow_d = '0;
    end else if (load) begin
      shadow_d = duty;
    end
    pwm_d = (enable && (period_cnt < shadow_q)) ^ INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      pwm_q    <= INV;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/axi_rgbled_pwm.sv
// Multi-LED RGB PWM controller behind the up_* register bus: shared prescaler and
// period counter in here, one rgbled_pwm_chan per colour per LED.
module axi_rgbled_pwm
  import axi_rgbled_pwm_pkg::*;
#(
  parameter int ID         = 0,
  parameter int NLEDS      = 4,
  parameter int PWM_WIDTH  = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             up_clk,
  input  logic             up_rstn,
  input  logic             up_wreq,
  input  logic [7:0]       up_waddr,
  input  logic [31:0]      up_wdata,
  output logic             up_wack,
  input  logic             up_rreq,
  input  logic [7:0]       up_raddr,
  output logic [31:0]      up_rdata,
  output logic             up_rack,
  output logic [NLEDS-1:0] o_red,
  output logic [NLEDS-1:0] o_green,
  output logic [NLEDS-1:0] o_blue
);

  localparam int W  = PWM_WIDTH;
  localparam int CW = 3 * PWM_WIDTH;
  localparam logic [W-1:0] PERIOD_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [31:0]   scratch_q, scratch_d;
  logic          enable_q, enable_d;
  logic [15:0]   prescale_q, prescale_d;
  logic [CW-1:0] color_q [NLEDS];
  logic [CW-1:0] color_d [NLEDS];
  logic [15:0]   pre_cnt_q, pre_cnt_d;
  logic [W-1:0]  period_q, period_d;
  logic          wack_q, wack_d;
  logic          rack_q, rack_d;
  logic [31:0]   rdata_q, rdata_d;

  logic tick;
  logic wrap;
  logic clr;
  logic shadow_load;
  logic [NLEDS-1:0][2:0] pwm_w;

  assign clr = up_wreq && (up_waddr == ADDR_CTRL) && up_wdata[CTRL_CLR_BIT];

  // Register writes; CLR takes effect on the write edge itself.
  always_comb begin
    scratch_d  = scratch_q;
    enable_d   = enable_q;
    prescale_d = prescale_q;
    for (int i = 0; i < NLEDS; i++) begin
      color_d[i] = color_q[i];
    end
    if (up_wreq) begin
      case (up_waddr)
        ADDR_SCRATCH:  scratch_d  = up_wdata;
        ADDR_CTRL:     enable_d   = up_wdata[CTRL_ENABLE_BIT];
        ADDR_PRESCALE: prescale_d = up_wdata[15:0];
        default: ;
      endcase
      for (int i = 0; i < NLEDS; i++) begin
        if (up_waddr == ADDR_COLOR_BASE + 8'(i)) begin
          color_d[i] = up_wdata[CW-1:0];
        end
      end
    end
    if (clr) begin
      for (int i = 0; i < NLEDS; i++) begin
        color_d[i] = '0;
      end
    end
  end

  // The >= compare lets a lowered PRESCALE take effect without a full 16-bit rollover.
  always_comb begin
    tick      = enable_q && (pre_cnt_q >= prescale_q);
    wrap      = tick && (period_q == PERIOD_LAST);
    pre_cnt_d = pre_cnt_q + 16'd1;
    period_d  = period_q;
    if (!enable_q || tick) begin
      pre_cnt_d = '0;
    end
    if (!enable_q || wrap) begin
      period_d = '0;
    end else if (tick) begin
      period_d = period_q + 1'b1;
    end
  end

  assign shadow_load = wrap || !enable_q;

  always_comb begin
    wack_d  = up_wreq;
    rack_d  = up_rreq;
    rdata_d = '0;
    if (up_rreq) begin
      case (up_raddr)
        ADDR_VERSION:  rdata_d = VERSION;
        ADDR_ID:       rdata_d = 32'(ID);
        ADDR_SCRATCH:  rdata_d = scratch_q;
        ADDR_CONFIG:   rdata_d = {16'h0000, 8'(PWM_WIDTH), 8'(NLEDS)};
        ADDR_CTRL:     rdata_d = {31'd0, enable_q};
        ADDR_PRESCALE: rdata_d = {16'h0000, prescale_q};
        default: ;
      endcase
      for (int i = 0; i < NLEDS; i++) begin
        if (up_raddr == ADDR_COLOR_BASE + 8'(i)) begin
          rdata_d = 32'(color_q[i]);
        end
      end
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      scratch_q  <= '0;
      enable_q   <= 1'b0;
      prescale_q <= '0;
      for (int i = 0; i < NLEDS; i++) begin
        color_q[i] <= '0;
      end
      pre_cnt_q  <= '0;
      period_q   <= '0;
      wack_q     <= 1'b0;
      rack_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      scratch_q  <= scratch_d;
      enable_q   <= enable_d;
      prescale_q <= prescale_d;
      for (int i = 0; i < NLEDS; i++) begin
        color_q[i] <= color_d[i];
      end
      pre_cnt_q  <= pre_cnt_d;
      period_q   <= period_d;
      wack_q     <= wack_d;
      rack_q     <= rack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign up_wack  = wack_q;
  assign up_rack  = rack_q;
  assign up_rdata = rdata_q;

  for (genvar gi = 0; gi < NLEDS; gi++) begin : g_led
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      rgbled_pwm_chan #(
        .PWM_WIDTH  (PWM_WIDTH),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
        .clk        (up_clk),
        .rst_n      (up_rstn),
        .enable     (enable_q),
        .load       (shadow_load),
        .clr        (clr),
        .duty       (color_q[gi][gc*W +: W]),
        .period_cnt (period_q),
        .pwm_o      (pwm_w[gi][gc])
      );
    end
    assign o_red[gi]   = pwm_w[gi][COL_RED];
    assign o_green[gi] = pwm_w[gi][COL_GREEN];
    assign o_blue[gi]  = pwm_w[gi][COL_BLUE];
  end

endmodule

// File: tb/tb_axi_rgbled_pwm.sv
// Directed bench: two controllers (active-high and active-low) share one register bus.
module tb_axi_rgbled_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wreq = 1'b0;
  logic [7:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        rreq = 1'b0;
  logic [7:0]  raddr = '0;

  logic        wack_a, rack_a, wack_b, rack_b;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cyc = 0;
  int cnt_a [3];
  int cnt_b [3];
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  axi_rgbled_pwm #(.ID(90), .NLEDS(4), .PWM_WIDTH(8), .ACTIVE_LOW(0)) dut_a (
    .up_clk(clk), .up_rstn(rst_n),
    .up_wreq(wreq), .up_waddr(waddr), .up_wdata(wdata), .up_wack(wack_a),
    .up_rreq(rreq), .up_raddr(raddr), .up_rdata(rdata_a), .up_rack(rack_a),
    .o_red(a_red), .o_green(a_green), .o_blue(a_blue)
  );

  axi_rgbled_pwm #(.ID(7), .NLEDS(4), .PWM_WIDTH(8), .ACTIVE_LOW(1)) dut_b (
    .up_clk(clk), .up_rstn(rst_n),
    .up_wreq(wreq), .up_waddr(waddr), .up_wdata(wdata), .up_wack(wack_b),
    .up_rreq(rreq), .up_raddr(raddr), .up_rdata(rdata_b), .up_rack(rack_b),
    .o_red(b_red), .o_green(b_green), .o_blue(b_blue)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2:0] led_a(input int i);
    return {a_red[i], a_green[i], a_blue[i]};
  endfunction

  function automatic logic [2:0] led_b(input int i);
    return {b_red[i], b_green[i], b_blue[i]};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wreq = 1'b1; waddr = a; wdata = d;
    step();
    wreq = 1'b0;
    chk("wack", {31'd0, wack_a}, 32'd1);
    $display("WR addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rreq = 1'b1; raddr = a;
    step();
    rreq = 1'b0;
    chk("rack", {31'd0, rack_a}, 32'd1);
    d = rdata_a;
    $display("RD addr=%h data=%h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // Counts high cycles per colour of one LED over n consecutive post-step samples.
  task automatic run_count(input int n, input int led);
    for (int i = 0; i < 3; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    for (int k = 0; k < n; k++) begin
      step();
      cnt_a[0] += int'(a_blue[led]);  cnt_b[0] += int'(b_blue[led]);
      cnt_a[1] += int'(a_green[led]); cnt_b[1] += int'(b_green[led]);
      cnt_a[2] += int'(a_red[led]);   cnt_b[2] += int'(b_red[led]);
    end
    $display("COUNT led=%0d n=%0d a(r,g,b)=%0d,%0d,%0d b(r,g,b)=%0d,%0d,%0d",
             led, n, cnt_a[2], cnt_a[1], cnt_a[0], cnt_b[2], cnt_b[1], cnt_b[0]);
  endtask

  initial begin
    int blue_hi_a, blue_hi_b;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_out_a", {20'd0, a_red, a_green, a_blue}, 32'h000);
    chk("rst_out_b", {20'd0, b_red, b_green, b_blue}, 32'hFFF);
    chk("rst_acks", {30'd0, wack_a, rack_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    rst_n = 1'b1;
    step();

    // Read handshake: ack exactly one cycle after the request, data only in the ack cycle
    rreq = 1'b1; raddr = 8'h00;
    chk("rack_before", {31'd0, rack_a}, 32'd0);
    step();
    rreq = 1'b0;
    chk("rack_ver", {31'd0, rack_a}, 32'd1);
    chk("version", rdata_a, 32'h0001_0061);
    step();
    chk("rack_drop", {31'd0, rack_a}, 32'd0);
    chk("rdata_idle", rdata_a, 32'd0);
    rd_chk("config", 8'h03, 32'h0000_0804);
    rreq = 1'b1; raddr = 8'h01;
    step();
    rreq = 1'b0;
    chk("id_a", rdata_a, 32'd90);
    chk("id_b", rdata_b, 32'd7);
    wr(8'h02, 32'hDEAD_BEEF);
    rd_chk("scratch", 8'h02, 32'hDEAD_BEEF);

    // Basic PWM at PRESCALE=0: 255-clock period
    wr(8'h10, 32'h00FF_4000);
    wr(8'h05, 32'd0);
    wr(8'h04, 32'd1);
    en_cyc = cyc;
    run_count(255, 0);
    chk("a_red0_ff", cnt_a[2], 255);
    chk("a_green0_40", cnt_a[1], 64);
    chk("a_blue0_00", cnt_a[0], 0);
    chk("b_red0_ff", cnt_b[2], 0);
    chk("b_green0_40", cnt_b[1], 191);
    chk("b_blue0_00", cnt_b[0], 255);

    // COLOR1 write landing in the wrap cycle applies one period late
    while (((cyc - en_cyc) % 255) != 254) step();
    wr(8'h11, 32'h0000_8000);
    run_count(255, 1);
    chk("a_green1_old", cnt_a[1], 0);
    chk("b_green1_old", cnt_b[1], 255);
    run_count(255, 1);
    chk("a_green1_new", cnt_a[1], 128);
    chk("b_green1_new", cnt_b[1], 127);

    // PRESCALE=3, blue duty 1: 4 clocks high per 1020-clock period
    wr(8'h04, 32'd0);
    wr(8'h10, 32'h0000_0001);
    wr(8'h05, 32'd3);
    wr(8'h04, 32'd1);
    run_count(1020, 0);
    chk("a_blue0_ps3", cnt_a[0], 4);
    chk("a_red0_ps3", cnt_a[2], 0);
    chk("b_blue0_ps3", cnt_b[0], 1016);

    // Lower PRESCALE 100 -> 2 while the prescaler sits at 50
    wr(8'h04, 32'd0);
    wr(8'h05, 32'd100);
    wr(8'h04, 32'd1);
    blue_hi_a = 0;
    blue_hi_b = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      blue_hi_a += int'(a_blue[0]);
      blue_hi_b += int'(b_blue[0]);
      if (k == 50) begin
        wreq = 1'b1; waddr = 8'h05; wdata = 32'd2;
      end else if (k == 51) begin
        wreq = 1'b0;
        chk("wack_ps", {31'd0, wack_a}, 32'd1);
      end
    end
    $display("PRESCALE drop: blue0 high a=%0d b_low=%0d", blue_hi_a, 300 - blue_hi_b);
    chk("a_blue0_psdrop", blue_hi_a, 52);
    chk("b_blue0_psdrop", 300 - blue_hi_b, 52);
    rd_chk("prescale_rb", 8'h05, 32'd2);

    // Unmapped / out-of-range addresses, unused COLOR bits
    wr(8'h20, 32'hFFFF_FFFF);
    wr(8'h17, 32'hFFFF_FFFF);
    rd_chk("unmapped_20", 8'h20, 32'd0);
    rd_chk("color7_oor", 8'h17, 32'd0);
    rd_chk("unmapped_06", 8'h06, 32'd0);
    wr(8'h13, 32'hFFFF_FFFF);
    rd_chk("color3_mask", 8'h13, 32'h00FF_FFFF);
    rd_chk("ctrl_rb", 8'h04, 32'd1);

    // CLR mid-period
    wr(8'h04, 32'd0);
    wr(8'h10, 32'h00FF_FFFF);
    wr(8'h05, 32'd0);
    wr(8'h04, 32'd1);
    repeat (3) step();
    chk("a_led0_on", {29'd0, led_a(0)}, 32'd7);
    wr(8'h04, 32'h3);
    step();
    chk("a_led0_clr", {29'd0, led_a(0)}, 32'd0);
    chk("b_led0_clr", {29'd0, led_b(0)}, 32'd7);
    rd_chk("color0_clr", 8'h10, 32'd0);
    rd_chk("color3_clr", 8'h13, 32'd0);
    rd_chk("ctrl_clr_rb", 8'h04, 32'd1);

    // Asynchronous reset mid-period
    wr(8'h04, 32'd0);
    wr(8'h10, 32'h00FF_FFFF);
    wr(8'h02, 32'h0000_1234);
    wr(8'h04, 32'd1);
    repeat (3) step();
    chk("a_led0_on2", {29'd0, led_a(0)}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("a_led0_async_rst", {29'd0, led_a(0)}, 32'd0);
    chk("b_led0_async_rst", {29'd0, led_b(0)}, 32'd7);
    step();
    step();
    rst_n = 1'b1;
    step();
    rd_chk("color0_rst", 8'h10, 32'd0);
    rd_chk("scratch_rst", 8'h02, 32'd0);
    rd_chk("ctrl_rst", 8'h04, 32'd0);
    rd_chk("prescale_rst", 8'h05, 32'd0);
    repeat (3) step();
    chk("a_out_after_rst", {20'd0, a_red, a_green, a_blue}, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rgbled_pwm.md
Name: axi_rgbled_pwm

Overview:
Parametrised multi-LED RGB PWM controller that sits behind the up_axi bridge in an AXI-Lite peripheral. It drives NLEDS RGB LEDs, with PWM_WIDTH-bit duty per colour. It adds a programmable prescaler, global enable, output polarity and glitch-free shadowed duty updates at PWM period boundaries. Register access uses the up_* request/ack protocol.

Parameters:
ID, 0, core instance ID, readable at 0x01
NLEDS, 4, number of RGB LEDs, 1..16
PWM_WIDTH, 8, duty/counter width per colour, 4..10
ACTIVE_LOW, 0, 1 inverts all LED outputs (common-anode LEDs)

Ports:
up_clk  in  1  single clock for registers and PWM
up_rstn  in  1  reset, asynchronous, active-low
up_wreq  in  1  write request, one-cycle pulse
up_waddr  in  8  write word address
up_wdata  in  32  write data
up_wack  out  1  write acknowledge
up_rreq  in  1  read request, one-cycle pulse
up_raddr  in  8  read word address
up_rdata  out  32  read data, valid with up_rack
up_rack  out  1  read acknowledge
o_red  out  NLEDS  red PWM outputs
o_green  out  NLEDS  green PWM outputs
o_blue  out  NLEDS  blue PWM outputs

Behaviour:
- Reset: up_wack=0, up_rack=0, up_rdata=0. o_* = inactive level (0, or all-ones if ACTIVE_LOW). All registers 0 except PRESCALE=0.
- Register map (word addresses):
  - 0x00 VERSION RO = 32'h0001_0061
  - 0x01 ID RO
  - 0x02 SCRATCH RW
  - 0x03 CONFIG RO: [7:0]=NLEDS, [15:8]=PWM_WIDTH
  - 0x04 CTRL: [0] ENABLE; [1] CLR, write-1 self-clearing, zeroes all COLOR registers and shadows in the next cycle, always reads 0
  - 0x05 PRESCALE: [15:0]
  - 0x10+n COLOR n, n<NLEDS, W=PWM_WIDTH: red=[3W-1:2W], green=[2W-1:W], blue=[W-1:0]; unused bits write-ignored, read 0
- Unmapped or n>=NLEDS addresses: writes ignored, reads return 0; both still acked.
- Handshake:
  - up_wack = up_wreq delayed 1 cycle.
  - up_rack = up_rreq delayed 1 cycle; up_rdata holds the register value in the ack cycle, 0 otherwise.
  - A request every cycle is legal.
- Prescaler:
  - 16-bit counter; tick when count>=PRESCALE, then count<=0. Tick period = PRESCALE+1 clocks.
  - The >= compare makes lowering PRESCALE mid-count safe.
- Period counter:
  - Increments on tick over 0..2^W-2 (2^W-1 ticks per period), then wraps to 0.
  - The wrap event is the tick when count=2^W-2.
- Shadows: per-colour duty shadows load from COLOR registers on the wrap event, and every cycle while ENABLE=0.
  - A COLOR write in the same cycle as wrap: shadow takes the pre-write value; the new value applies from the next wrap.
- Output:
  - pwm = (period_cnt < shadow); duty 0 gives constant off, duty 2^W-1 gives constant on.
  - Registered: output changes 1 clock after the counter edge. XOR with ACTIVE_LOW.
- ENABLE=0: prescaler and period counters held at 0; outputs inactive.
  - On ENABLE 0->1, counting starts with current COLOR values, and the first output is evaluated at period_cnt=0.
- Reset asserted mid-period: all state clears asynchronously; outputs go inactive immediately.

Decomposition:
- Package axi_rgbled_pwm_pkg holds:
  - register address constants (ADDR_VERSION, ADDR_ID, ADDR_SCRATCH, ADDR_CONFIG, ADDR_CTRL, ADDR_PRESCALE, ADDR_COLOR_BASE)
  - VERSION constant
  - CTRL bit indices
- Sub-module rgbled_pwm_chan (parameter PWM_WIDTH): shadow register, comparator and registered output for one colour. Instantiate 3*NLEDS times via generate.
- Prescaler and period counter are shared in the top.

Test Plan:
- Reset, then read 0x00/0x03 with NLEDS=4, W=8 -> rack 1 cycle after rreq; data 0x00010061 and 0x00000804; all o_*=0.
- Write COLOR0=0x00FF4000, PRESCALE=0, ENABLE=1 -> period 255 clocks; red0 high 255/255, green0 high 64 clocks per period, blue0 constantly low.
- Write COLOR1 green=0x80 in the exact wrap cycle -> current period keeps old duty; next period green1 is high for 128 clocks.
- PRESCALE=3, COLOR0 blue=0x01 -> blue0 high for 4 clocks per 1020-clock period; change PRESCALE from 100 to 2 while the count is at 50 -> next tick in the following cycle, with no hang.
- ACTIVE_LOW=1, duty 0 and duty 0xFF, then write 0x20 and COLOR7 and read them -> outputs constantly 1 and 0 respectively; unmapped writes acked, reads return 0.
- CTRL CLR write mid-period, then assert up_rstn low mid-period -> COLOR registers read 0 and outputs go inactive next cycle; on reset, outputs go inactive asynchronously and registers read reset values.
